// File: rtl/ifu_fetch_stage_if.sv
// ifu_fetch_stage_if: single-outstanding instruction fetch request/response bus.
interface ifu_fetch_stage_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
    modport slave (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/ifu_fetch_stage.sv
// ifu_fetch_stage: PC register, single-outstanding fetch FSM and IF/ID register.
// Define IFU_MISALIGN_CHECK_EN to trap misaligned jump targets on inst_misalign_o.
module ifu_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               jump_flag_i,
    input  logic [31:0]        jump_addr_i,
    input  logic [2:0]         hold_flag_i,
    input  logic               pip_flush_i,
    ifu_fetch_stage_if.master  bus,
    output logic [31:0]        inst_o,
    output logic [31:0]        inst_addr_o,
    output logic               inst_valid_o,
`ifdef IFU_MISALIGN_CHECK_EN
    output logic               inst_misalign_o,
`endif
    output logic               stallreq_from_if_o
);
    typedef enum logic [1:0] {REQ, WAIT, BUF} state_t;
    state_t state, state_nxt;
    logic [31:0] pc, pc_nxt, addr_q, skid, dlv_data;
    logic kill, kill_nxt, vld_q, hold_id, hand, rsp_ok, deliver, mis_jump, blocked;

    assign hold_id  = hold_flag_i >= 3'd2;
    assign hand     = bus.req_valid & bus.req_ready;
    assign rsp_ok   = state == WAIT & bus.rsp_valid & !kill;
    assign deliver  = !hold_id & (rsp_ok | state == BUF);
    assign dlv_data = state == BUF ? skid : bus.rsp_data;

`ifdef IFU_MISALIGN_CHECK_EN
    logic mis_q;
    assign mis_jump        = jump_flag_i & |jump_addr_i[1:0];
    assign blocked         = mis_q;
    assign inst_misalign_o = mis_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mis_q <= 1'b0;
        else if (jump_flag_i | pip_flush_i) mis_q <= mis_jump;
    end
`else
    assign mis_jump = 1'b0;
    assign blocked  = 1'b0;
`endif

    // A request that was raised but not yet accepted stays up with its captured address.
    assign bus.req_valid      = !rst & state == REQ & (vld_q | (hold_flag_i == 3'd0 & !blocked));
    assign bus.req_addr       = vld_q ? addr_q : pc;
    assign stallreq_from_if_o = !rst & state != BUF;

    always_comb begin
        state_nxt = state;
        pc_nxt    = deliver ? pc + 32'd4 : pc;
        kill_nxt  = kill;
        if (state == REQ & hand) state_nxt = WAIT;
        if (state == WAIT & bus.rsp_valid) begin
            state_nxt = rsp_ok & hold_id ? BUF : REQ;
            kill_nxt  = 1'b0;
        end
        if (state == BUF & !hold_id) state_nxt = REQ;
        // A jump marks any request already on the bus so its response is dropped.
        if (jump_flag_i) begin
            pc_nxt    = jump_addr_i & ~32'd3;
            kill_nxt  = bus.req_valid | (state == WAIT & !bus.rsp_valid);
            state_nxt = hand | (state == WAIT & !bus.rsp_valid) ? WAIT : REQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= REQ;
            pc           <= RESET_PC;
            kill         <= 1'b0;
            vld_q        <= 1'b0;
            addr_q       <= RESET_PC;
            skid         <= NOP_INST;
            inst_o       <= NOP_INST;
            inst_addr_o  <= '0;
            inst_valid_o <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
            vld_q <= bus.req_valid & !bus.req_ready;
            if (bus.req_valid) addr_q <= bus.req_addr;
            if (rsp_ok & hold_id) skid <= bus.rsp_data;
            if (mis_jump) begin
                inst_o       <= NOP_INST;
                inst_addr_o  <= jump_addr_i;
                inst_valid_o <= 1'b1;
            end else if (jump_flag_i | pip_flush_i) begin
                inst_o       <= NOP_INST;
                inst_addr_o  <= '0;
                inst_valid_o <= 1'b0;
            end else if (!hold_id) begin
                inst_o       <= deliver ? dlv_data : NOP_INST;
                inst_valid_o <= deliver;
                if (deliver) inst_addr_o <= pc;
            end
        end
    end
endmodule
